// File: rtl/sum_serial_ctrl.sv
// Bit-serial adder: computes {Cout,S} = A + B + Ci one bit per clock through
// a single shared 1-bit full adder, with a start/busy/done handshake.

module sum1b (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Cout,
  output logic S
);
  assign S    = A ^ B ^ Ci;
  assign Cout = (A & B) | (Ci & (A ^ B));
endmodule

module sum_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_c;
  logic [N-1:0]  r_s;
  logic          r_cout;
  logic [CW-1:0] r_cnt;
  logic          w_sum;
  logic          w_carry;
  logic          w_last;

  sum1b u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Ci   (r_c),
    .Cout (w_carry),
    .S    (w_sum)
  );

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, then shift LSB-first through the adder
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_c   <= Ci;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_carry;
          r_s   <= N'({w_sum, r_s} >> 1);
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_cout <= w_carry;
        end
        default: ;
      endcase
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Directed bench for sum_serial_ctrl at N=8, N=4 and N=1.

module tb_sum_serial_ctrl;
  logic clk = 1'b0;
  logic rst;

  logic       st8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, s8;
  logic       st4, ci4, busy4, done4, co4;
  logic [3:0] a4, b4, s4;
  logic       st1, ci1, busy1, done1, co1;
  logic [0:0] a1, b1, s1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_serial_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Ci(ci8),
    .busy(busy8), .done(done8), .S(s8), .Cout(co8)
  );
  sum_serial_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .A(a4), .B(b4), .Ci(ci4),
    .busy(busy4), .done(done4), .S(s4), .Cout(co4)
  );
  sum_serial_ctrl #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .Ci(ci1),
    .busy(busy1), .done(done1), .S(s1), .Cout(co1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start was driven high at the current negedge; follow the op to its done pulse.
  task automatic wait8(input logic [7:0] es, input logic ec, input bit chg, input string tag);
    int n, nb;
    @(negedge clk);
    st8 = 1'b0;
    if (chg) begin
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    end
    n = 0; nb = 0;
    while (!done8 && n < 30) begin
      if (busy8) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy"}, nb, 8);
    chk({tag, "_S"}, s8, es);
    chk({tag, "_Cout"}, co8, ec);
    chk({tag, "_excl"}, busy8 & done8, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done8, 0);
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec, input bit chg, input string tag);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; st8 = 1'b1;
    wait8(es, ec, chg, tag);
  endtask

  // Returns the observed {Cout,S} and latency for the N=4 or N=1 instance.
  task automatic add_small(input int w, input logic [3:0] a, input logic [3:0] b, input logic ci,
                           output logic [4:0] res, output int n);
    @(negedge clk);
    if (w == 4) begin a4 = a; b4 = b; ci4 = ci; st4 = 1'b1; end
    else        begin a1 = a[0:0]; b1 = b[0:0]; ci1 = ci; st1 = 1'b1; end
    @(negedge clk);
    st4 = 1'b0; st1 = 1'b0;
    n = 0;
    while (!(w == 4 ? done4 : done1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    res = (w == 4) ? {co4, s4} : {3'b000, co1, s1};
    n = n + 1;
  endtask

  initial begin
    logic [4:0] res;
    logic [4:0] exp5;
    logic [1:0] tbl1 [8];
    int n, lat_err, val_err, pulses, last_at, gap_err, both;

    tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    st4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    st1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_S", s8, 0);
    chk("rst_Cout", co8, 0);
    chk("rst_S4", {co4, s4}, 0);

    // Start on the very first edge after reset release
    rst = 1'b0;
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
    wait8(8'h00, 1'b1, 1'b0, "ff_01");

    add8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, "aa_55_c");
    add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "zero_c");
    add8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, "opchg");
    add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "msb_ovf");
    add8(8'h5A, 8'h21, 1'b0, 8'h7B, 1'b0, 1'b0, "plain");

    // Start held high: back-to-back ops every N+2 cycles
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; st8 = 1'b1;
    pulses = 0; last_at = -1; gap_err = 0; val_err = 0; both = 0;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      if (busy8 && done8) both++;
      if (done8) begin
        if (last_at >= 0 && (c - last_at) != 10) gap_err++;
        if ({co8, s8} != 9'h046) val_err++;
        last_at = c;
        pulses++;
      end
    end
    st8 = 1'b0;
    chk("held_pulses", pulses, 4);
    chk("held_gap", gap_err, 0);
    chk("held_val", val_err, 0);
    chk("held_excl", both, 0);
    repeat (12) @(negedge clk);

    // Reset during the 4th RUN cycle aborts the op
    a8 = 8'h55; b8 = 8'h33; ci8 = 1'b1; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_S", s8, 0);
    chk("abort_Cout", co8, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    add8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, "after_abort");

    // N=1: registered full adder
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      add_small(1, {3'b000, v[2]}, {3'b000, v[1]}, v[0], res, n);
      chk($sformatf("n1_%0d", i), res, {3'b000, tbl1[i]});
      chk($sformatf("n1_lat%0d", i), n, 2);
    end

    // N=4: exhaustive
    lat_err = 0; val_err = 0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      exp5 = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
      add_small(4, v[8:5], v[4:1], v[0], res, n);
      chk($sformatf("n4_%0d", i), res, exp5);
      if (n != 5) lat_err++;
    end
    chk("n4_lat", lat_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
